// File: rtl/two_bit_cnt_pkg.sv
// rtl/two_bit_cnt_pkg.sv - shared constants, direction enum and Gray helper for two_bit_cnt
package two_bit_cnt_pkg;

  localparam int CNT_W_DEFAULT = 2;
  localparam int CNT_W_MAX     = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Sized for the widest legal counter; callers zero-extend and take the low bits.
  function automatic logic [CNT_W_MAX-1:0] bin2gray(input logic [CNT_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/two_bit_cnt_next.sv
// rtl/two_bit_cnt_next.sv - combinational next-count and terminal-count logic
module two_bit_cnt_next
  import two_bit_cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_W_DEFAULT,
  parameter int RST_VAL = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             rst,
  output logic [WIDTH-1:0] q_next,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  dir_e dir;
  assign dir = dir_e'(up);

  always_comb begin
    q_next = q;
    if (rst) begin
      q_next = RST_Q;
    end else if (ld) begin
      q_next = d;
    end else if (en) begin
      if (dir == DIR_UP) q_next = q + WIDTH'(1);
      else               q_next = q - WIDTH'(1);
    end
  end

  // tc flags the cycle whose edge wraps; reset and load cycles never wrap.
  always_comb begin
    tc = 1'b0;
    if (en && !rst && !ld) begin
      if (dir == DIR_UP) tc = (q == {WIDTH{1'b1}});
      else               tc = (q == '0);
    end
  end

endmodule

// File: rtl/two_bit_cnt.sv
// rtl/two_bit_cnt.sv - modulo-2^WIDTH up/down counter with load and tc; GRAY_OUT_EN adds q_gray
module two_bit_cnt
  import two_bit_cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_W_DEFAULT,
  parameter int RST_VAL = 0
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
`ifdef GRAY_OUT_EN
  output logic [WIDTH-1:0] q_gray,
`endif
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  two_bit_cnt_next #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_next (
    .q      (cnt_q),
    .en     (en),
    .up     (up),
    .ld     (ld),
    .d      (d),
    .rst    (rst),
    .q_next (cnt_d),
    .tc     (tc)
  );

  always_ff @(posedge c) begin
    if (rst) cnt_q <= RST_Q;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

`ifdef GRAY_OUT_EN
  localparam logic [CNT_W_MAX-1:0] RST_GRAY_W = bin2gray(CNT_W_MAX'(RST_Q));

  logic [WIDTH-1:0]     gray_q;
  logic [WIDTH-1:0]     gray_d;
  logic [CNT_W_MAX-1:0] gray_w;

  // Encode the next count so q_gray moves on the same edge as q.
  always_comb begin
    gray_w = bin2gray(CNT_W_MAX'(cnt_d));
    gray_d = gray_w[WIDTH-1:0];
  end

  always_ff @(posedge c) begin
    if (rst) gray_q <= RST_GRAY_W[WIDTH-1:0];
    else     gray_q <= gray_d;
  end

  assign q_gray = gray_q;
`endif

endmodule

// File: tb/tb_two_bit_cnt.sv
// tb/tb_two_bit_cnt.sv - scoreboard bench for two_bit_cnt (WIDTH=2, RST_VAL=0)
module tb_two_bit_cnt;

  logic       c = 1'b0;
  logic       rst, en, up, ld;
  logic [1:0] d;
  logic [1:0] q;
  logic       tc;
`ifdef GRAY_OUT_EN
  logic [1:0] q_gray;
`endif

  always #5 c = ~c;

  two_bit_cnt #(.WIDTH(2), .RST_VAL(0)) dut (
    .c      (c),
    .rst    (rst),
    .en     (en),
    .up     (up),
    .ld     (ld),
    .d      (d),
    .q      (q),
`ifdef GRAY_OUT_EN
    .q_gray (q_gray),
`endif
    .tc     (tc)
  );

  typedef struct {
    logic       rst, en, up, ld;
    logic [1:0] d;
    logic       chk_q;
    logic [1:0] q;   // q held during this cycle, before the edge
    logic       tc;  // tc with these inputs applied
  } vec_t;

  typedef struct {
    logic       chk_q;
    logic [1:0] q;
    logic       tc;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] g_exp;

  task automatic add(input logic r, input logic en_i, input logic up_i, input logic ld_i,
                     input logic [1:0] d_i, input logic chk, input logic [1:0] q_i,
                     input logic tc_i);
    vec_t v;
    v.rst = r; v.en = en_i; v.up = up_i; v.ld = ld_i; v.d = d_i;
    v.chk_q = chk; v.q = q_i; v.tc = tc_i;
    vq.push_back(v);
  endtask

  // Monitor: one scoreboard entry per cycle, checked mid-cycle with inputs stable.
  always @(negedge c) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_q) begin
        n_tests++;
        if (q !== e.q) begin
          n_fail++;
          $display("FAIL q: got %b expected %b at %0t", q, e.q, $time);
        end
`ifdef GRAY_OUT_EN
        g_exp = e.q ^ (e.q >> 1);
        n_tests++;
        if (q_gray !== g_exp) begin
          n_fail++;
          $display("FAIL q_gray: got %b expected %b at %0t", q_gray, g_exp, $time);
        end
`endif
      end
      n_tests++;
      if (tc !== e.tc) begin
        n_fail++;
        $display("FAIL tc: got %b expected %b (q exp %b) at %0t", tc, e.tc, e.q, $time);
      end
    end
  end

  initial begin
    int budget;
    exp_t x;
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; d = 2'b00;

    //   rst en up ld d    chk q     tc
    add(1, 1, 1, 0, 2'd0, 0, 2'd0, 0); // q unknown before first reset edge
    add(1, 1, 1, 0, 2'd0, 1, 2'd0, 0); // held in reset, tc suppressed
    add(0, 1, 1, 0, 2'd0, 1, 2'd0, 0);
    add(0, 1, 1, 0, 2'd0, 1, 2'd1, 0);
    add(0, 1, 1, 0, 2'd0, 1, 2'd2, 0);
    add(0, 1, 1, 0, 2'd0, 1, 2'd3, 1); // up wrap ahead
    add(0, 0, 1, 1, 2'd0, 1, 2'd0, 0); // load 00
    add(0, 1, 0, 0, 2'd0, 1, 2'd0, 1); // down wrap ahead
    add(0, 1, 0, 0, 2'd0, 1, 2'd3, 0);
    add(0, 1, 0, 0, 2'd0, 1, 2'd2, 0);
    add(0, 1, 0, 0, 2'd0, 1, 2'd1, 0);
    add(0, 1, 0, 0, 2'd0, 1, 2'd0, 1);
    add(0, 0, 0, 1, 2'd1, 1, 2'd3, 0); // en low: no tc at q=3 down anyway; load 01
    add(0, 1, 1, 1, 2'd2, 1, 2'd1, 0); // load beats count
    add(0, 0, 1, 0, 2'd0, 1, 2'd2, 0); // hold x3
    add(0, 0, 1, 0, 2'd0, 1, 2'd2, 0);
    add(0, 0, 1, 0, 2'd0, 1, 2'd2, 0);
    add(1, 1, 1, 1, 2'd3, 1, 2'd2, 0); // reset beats load
    add(0, 1, 0, 0, 2'd0, 1, 2'd0, 1);
    add(0, 1, 1, 1, 2'd0, 1, 2'd3, 0); // tc suppressed by ld at q=3 up
    add(0, 0, 1, 0, 2'd0, 1, 2'd0, 0);
    add(1, 1, 0, 0, 2'd0, 1, 2'd0, 0); // tc suppressed by rst at q=0 down
    add(0, 0, 0, 0, 2'd0, 1, 2'd0, 0);
    add(0, 1, 1, 0, 2'd0, 1, 2'd0, 0);
    add(0, 0, 1, 0, 2'd0, 1, 2'd1, 0);

    @(posedge c);
    foreach (vq[i]) begin
      #1;
      rst = vq[i].rst; en = vq[i].en; up = vq[i].up; ld = vq[i].ld; d = vq[i].d;
      x.chk_q = vq[i].chk_q; x.q = vq[i].q; x.tc = vq[i].tc;
      sb.push_back(x);
      @(posedge c);
    end
    #1;
    en = 1'b0; ld = 1'b0; rst = 1'b0;

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge c);
      budget++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
